// File: rtl/mbox_channel_ctl.sv
// MBOX channel control: command-list fetch, CCW decode, data-word
// address generation and logout for NCH DMA channels.
module mbox_channel_ctl #(
    parameter int NCH = 8,
    parameter int AW  = 22
) (
    input  logic           mboxClk,
    input  logic           reset,
    input  logic [NCH-1:0] chStart,
    input  logic [NCH-1:0] chReq,
    input  logic           memAck,
    input  logic           memErr,
    input  logic [35:0]    memRData,
    output logic           memReq,
    output logic           memWrite,
    output logic [AW-1:0]  memAddr,
    output logic [35:0]    memWData,
    output logic [NCH-1:0] chGrant,
    output logic           chDataValid,
    output logic [AW-1:0]  chDataAddr,
    output logic           chReverse,
    output logic [NCH-1:0] chActive,
    output logic [NCH-1:0] chDone,
    output logic [NCH-1:0] chError
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ICP_RD,
        CCW_RD,
        STORE,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cur_q, cur_d;
    logic [NCH-1:0]             pend_q, pend_d;
    logic [NCH-1:0]             act_q, act_d;
    logic [NCH-1:0]             err_q, err_d;
    logic [NCH-1:0][AW-1:0]     clp_q, clp_d;
    logic [NCH-1:0][10:0]       wc_q, wc_d;
    logic [NCH-1:0][AW-1:0]     da_q, da_d;
    logic [NCH-1:0]             halt_q, halt_d;
    logic [NCH-1:0]             rev_q, rev_d;
    logic                       mreq_q, mreq_d;
    logic                       mwr_q, mwr_d;
    logic [AW-1:0]              maddr_q, maddr_d;
    logic [35:0]                mwdata_q, mwdata_d;
    logic [NCH-1:0]             grant_q, grant_d;
    logic                       dvalid_q, dvalid_d;
    logic [AW-1:0]              daddr_q, daddr_d;
    logic                       drev_q, drev_d;

    logic                       ack;
    logic                       pany, rany;
    logic [CW-1:0]              psel, rsel;

    // Arbitration, FSM next state and all register updates
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        act_d    = act_q;
        err_d    = err_q;
        clp_d    = clp_q;
        wc_d     = wc_q;
        da_d     = da_q;
        halt_d   = halt_q;
        rev_d    = rev_q;
        mreq_d   = mreq_q;
        mwr_d    = mwr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        grant_d  = '0;
        dvalid_d = 1'b0;
        daddr_d  = '0;
        drev_d   = 1'b0;
        pany     = 1'b0;
        rany     = 1'b0;
        psel     = '0;
        rsel     = '0;
        ack      = memAck & mreq_q;

        // Downward scan so the lowest index is the one left selected
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pany = 1'b1;
                psel = CW'(i);
            end
            if (chReq[i] && act_q[i] && (wc_q[i] != 11'd0)) begin
                rany = 1'b1;
                rsel = CW'(i);
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (chStart[i] && !act_q[i]) begin
                pend_d[i] = 1'b1;
                err_d[i]  = 1'b0;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pany) begin
                    cur_d        = psel;
                    pend_d[psel] = 1'b0;
                    state_d      = ICP_RD;
                end else if (rany) begin
                    grant_d[rsel] = 1'b1;
                    dvalid_d      = 1'b1;
                    daddr_d       = da_q[rsel];
                    drev_d        = rev_q[rsel];
                    da_d[rsel]    = rev_q[rsel] ? da_q[rsel] - AW'(1)
                                                : da_q[rsel] + AW'(1);
                    wc_d[rsel]    = wc_q[rsel] - 11'd1;
                    if (wc_q[rsel] == 11'd1) begin
                        cur_d = rsel;
                        if (halt_q[rsel]) begin
                            state_d = STORE;
                        end else begin
                            clp_d[rsel] = clp_q[rsel] + AW'(1);
                            state_d     = CCW_RD;
                        end
                    end
                end
            end
            ICP_RD: begin
                if (!mreq_q) begin
                    mreq_d   = 1'b1;
                    mwr_d    = 1'b0;
                    maddr_d  = AW'({cur_q, 2'b00});
                    mwdata_d = '0;
                end else if (ack) begin
                    mreq_d = 1'b0;
                    if (memErr) begin
                        err_d[cur_q] = 1'b1;
                        state_d      = STORE;
                    end else begin
                        clp_d[cur_q] = memRData[AW-1:0];
                        act_d[cur_q] = 1'b1;
                        state_d      = CCW_RD;
                    end
                end
            end
            CCW_RD: begin
                if (!mreq_q) begin
                    mreq_d   = 1'b1;
                    mwr_d    = 1'b0;
                    maddr_d  = clp_q[cur_q];
                    mwdata_d = '0;
                end else if (ack) begin
                    mreq_d = 1'b0;
                    if (memErr) begin
                        err_d[cur_q] = 1'b1;
                        state_d      = STORE;
                    end else if (memRData[35]) begin
                        wc_d[cur_q]   = memRData[32:22];
                        da_d[cur_q]   = memRData[AW-1:0];
                        halt_d[cur_q] = memRData[34];
                        rev_d[cur_q]  = memRData[33];
                        if (memRData[32:22] != 11'd0) begin
                            state_d = IDLE;
                        end else if (memRData[34]) begin
                            state_d = STORE;
                        end else begin
                            clp_d[cur_q] = clp_q[cur_q] + AW'(1);
                        end
                    end else if (memRData[34]) begin
                        clp_d[cur_q] = memRData[AW-1:0];
                    end else begin
                        state_d = STORE;
                    end
                end
            end
            STORE: begin
                if (!mreq_q) begin
                    mreq_d   = 1'b1;
                    mwr_d    = 1'b1;
                    maddr_d  = AW'({cur_q, 2'b01});
                    mwdata_d = {1'b1, err_q[cur_q], 1'b0,
                                wc_q[cur_q], clp_q[cur_q]};
                end else if (ack) begin
                    mreq_d  = 1'b0;
                    mwr_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                act_d[cur_q] = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and per-channel registers
    always_ff @(posedge mboxClk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            pend_q   <= '0;
            act_q    <= '0;
            err_q    <= '0;
            clp_q    <= '0;
            wc_q     <= '0;
            da_q     <= '0;
            halt_q   <= '0;
            rev_q    <= '0;
            mreq_q   <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            grant_q  <= '0;
            dvalid_q <= 1'b0;
            daddr_q  <= '0;
            drev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            err_q    <= err_d;
            clp_q    <= clp_d;
            wc_q     <= wc_d;
            da_q     <= da_d;
            halt_q   <= halt_d;
            rev_q    <= rev_d;
            mreq_q   <= mreq_d;
            mwr_q    <= mwr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            grant_q  <= grant_d;
            dvalid_q <= dvalid_d;
            daddr_q  <= daddr_d;
            drev_q   <= drev_d;
        end
    end

    // Done pulse is the decoded DONE state for the channel in service
    always_comb begin
        chDone = '0;
        if (state_q == DONE) begin
            chDone[cur_q] = 1'b1;
        end
    end

    assign memReq      = mreq_q;
    assign memWrite    = mwr_q;
    assign memAddr     = maddr_q;
    assign memWData    = mwdata_q;
    assign chGrant     = grant_q;
    assign chDataValid = dvalid_q;
    assign chDataAddr  = daddr_q;
    assign chReverse   = drev_q;
    assign chActive    = act_q;
    assign chError     = err_q;

endmodule

// File: tb/tb_mbox_channel_ctl.sv
// Testbench for mbox_channel_ctl: memory model with access scoreboard,
// grant scoreboard, table-driven single-CCW cases and corner sequences.
module tb_mbox_channel_ctl;

    localparam int NCH = 8;
    localparam int AW  = 22;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] chStart;
    logic [NCH-1:0] chReq;
    logic           memAck;
    logic           memErr;
    logic [35:0]    memRData;
    logic           memReq;
    logic           memWrite;
    logic [AW-1:0]  memAddr;
    logic [35:0]    memWData;
    logic [NCH-1:0] chGrant;
    logic           chDataValid;
    logic [AW-1:0]  chDataAddr;
    logic           chReverse;
    logic [NCH-1:0] chActive;
    logic [NCH-1:0] chDone;
    logic [NCH-1:0] chError;

    mbox_channel_ctl #(.NCH(NCH), .AW(AW)) dut (
        .mboxClk    (clk),
        .reset      (rst),
        .chStart    (chStart),
        .chReq      (chReq),
        .memAck     (memAck),
        .memErr     (memErr),
        .memRData   (memRData),
        .memReq     (memReq),
        .memWrite   (memWrite),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .chGrant    (chGrant),
        .chDataValid(chDataValid),
        .chDataAddr (chDataAddr),
        .chReverse  (chReverse),
        .chActive   (chActive),
        .chDone     (chDone),
        .chError    (chError)
    );

    typedef struct {
        logic        wr;
        logic [21:0] addr;
        logic [35:0] data;
    } macc_t;

    typedef struct {
        int          ch;
        logic [21:0] addr;
        logic        rev;
    } gnt_t;

    typedef struct {
        int          ch;
        logic [21:0] clp;
        logic [10:0] wc;
        logic [21:0] da;
        logic        rev;
        logic [35:0] exp_log;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    macc_t       mem_q[$];
    gnt_t        gnt_q[$];
    logic [35:0] mem [logic [21:0]];
    logic        err_arm;
    logic [21:0] err_addr;
    vec_t        tbl[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [21:0] a);
        macc_t e;
        e.wr = 1'b0; e.addr = a; e.data = '0;
        mem_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [21:0] a, input logic [35:0] d);
        macc_t e;
        e.wr = 1'b1; e.addr = a; e.data = d;
        mem_q.push_back(e);
    endtask

    task automatic exp_gr(input int ch, input logic [21:0] a,
                          input logic rv);
        gnt_t g;
        g.ch = ch; g.addr = a; g.rev = rv;
        gnt_q.push_back(g);
    endtask

    // Memory: one wait cycle, then ack; every access checked in order
    initial begin
        int    cnt;
        macc_t e;
        cnt      = 0;
        memAck   = 1'b0;
        memErr   = 1'b0;
        memRData = '0;
        forever begin
            @(negedge clk);
            if (rst || memAck) begin
                memAck = 1'b0;
                memErr = 1'b0;
                cnt    = 0;
            end else if (memReq) begin
                cnt++;
                if (cnt >= 2) begin
                    memAck = 1'b1;
                    memRData = '0;
                    if (!memWrite && mem.exists(memAddr))
                        memRData = mem[memAddr];
                    if (!memWrite && err_arm && memAddr == err_addr) begin
                        memErr  = 1'b1;
                        err_arm = 1'b0;
                    end
                    if (mem_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_unexpected actual=wr%0d@%0o required=none",
                                 memWrite, memAddr);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_wr", 64'(memWrite), 64'(e.wr));
                        chk("mem_addr", 64'(memAddr), 64'(e.addr));
                        if (e.wr)
                            chk("mem_wdata", 64'(memWData), 64'(e.data));
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Grant monitor
    initial begin
        gnt_t       g;
        logic [7:0] oh;
        forever begin
            @(negedge clk);
            if (!rst && chDataValid) begin
                if (gnt_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL gnt_unexpected actual=%0h@%0o required=none",
                             chGrant, chDataAddr);
                end else begin
                    g  = gnt_q.pop_front();
                    oh = 8'b1 << g.ch;
                    chk("gnt_onehot", 64'(chGrant), 64'(oh));
                    chk("gnt_addr", 64'(chDataAddr), 64'(g.addr));
                    chk("gnt_rev", 64'(chReverse), 64'(g.rev));
                end
            end else if (!rst && chGrant != '0) begin
                chk("gnt_without_valid", 64'(chGrant), 64'(0));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [7:0] m);
        chStart = m;
        @(negedge clk);
        chStart = '0;
    endtask

    task automatic wait_done(input int ch);
        logic       got;
        logic [7:0] oh;
        got = 1'b0;
        oh  = 8'b1 << ch;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (chDone[ch]) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'(1));
        if (got) begin
            chk("done_onehot", 64'(chDone), 64'(oh));
            @(negedge clk);
            chk("active_clear", 64'(chActive[ch]), 64'(0));
            chk("done_pulse", 64'(chDone), 64'(0));
        end
    endtask

    task automatic wait_mem(input int left);
        for (int n = 0; n < 400 && mem_q.size() > left; n++)
            @(negedge clk);
        chk("mem_drain", 64'(mem_q.size() <= left), 64'(1));
    endtask

    initial begin
        vec_t        v;
        logic [21:0] a;
        rst      = 1'b1;
        chStart  = '0;
        chReq    = '0;
        err_arm  = 1'b0;
        err_addr = '0;

        tbl[0] = '{2, 22'o100, 11'd3, 22'o2000, 1'b0, 36'o400000000100};
        tbl[1] = '{4, 22'o200, 11'd2, 22'o500, 1'b1, 36'o400000000200};
        tbl[2] = '{0, 22'o400, 11'd2, 22'o0, 1'b1, 36'o400000000400};
        tbl[3] = '{7, 22'o600, 11'd2, 22'o17777777, 1'b0, 36'o400000000600};
        tbl[4] = '{3, 22'o700, 11'd0, 22'o1234, 1'b0, 36'o400000000700};

        repeat (2) @(negedge clk);
        chk("rst_memReq", 64'(memReq), 64'(0));
        chk("rst_memWrite", 64'(memWrite), 64'(0));
        chk("rst_memAddr", 64'(memAddr), 64'(0));
        chk("rst_memWData", 64'(memWData), 64'(0));
        chk("rst_chGrant", 64'(chGrant), 64'(0));
        chk("rst_chDataValid", 64'(chDataValid), 64'(0));
        chk("rst_chDataAddr", 64'(chDataAddr), 64'(0));
        chk("rst_chReverse", 64'(chReverse), 64'(0));
        chk("rst_chActive", 64'(chActive), 64'(0));
        chk("rst_chDone", 64'(chDone), 64'(0));
        chk("rst_chError", 64'(chError), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single halt-after data CCW per channel
        for (int t = 0; t < 5; t++) begin
            v = tbl[t];
            mem[22'(4 * v.ch)] = {14'b0, v.clp};
            mem[v.clp] = {1'b1, 1'b1, v.rev, v.wc, v.da};
            exp_rd(22'(4 * v.ch));
            exp_rd(v.clp);
            exp_wr(22'(4 * v.ch + 1), v.exp_log);
            a = v.da;
            for (int k = 0; k < int'(v.wc); k++) begin
                exp_gr(v.ch, a, v.rev);
                a = v.rev ? a - 22'd1 : a + 22'd1;
            end
            pulse_start(8'b1 << v.ch);
            chReq = 8'b1 << v.ch;
            wait_done(v.ch);
            chReq = '0;
            @(negedge clk);
            chk("tbl_error", 64'(chError[v.ch]), 64'(0));
        end

        // Chained: data CCW without halt-after, jump, halt
        mem[22'd24]    = {14'b0, 22'o1000};
        mem[22'o1000]  = {1'b1, 1'b0, 1'b0, 11'd1, 22'o3000};
        mem[22'o1001]  = {2'b01, 12'b0, 22'o1300};
        mem[22'o1300]  = '0;
        exp_rd(22'd24);
        exp_rd(22'o1000);
        exp_gr(6, 22'o3000, 1'b0);
        exp_rd(22'o1001);
        exp_rd(22'o1300);
        exp_wr(22'd25, 36'o400000001300);
        pulse_start(8'b0100_0000);
        chReq = 8'b0100_0000;
        wait_done(6);
        chReq = '0;

        // Same-cycle starts: channel 1 served before channel 5
        mem[22'd4]    = {14'b0, 22'o2100};
        mem[22'o2100] = '0;
        mem[22'd20]   = {14'b0, 22'o2200};
        mem[22'o2200] = '0;
        exp_rd(22'd4);
        exp_rd(22'o2100);
        exp_wr(22'd5, 36'o400000002100);
        exp_rd(22'd20);
        exp_rd(22'o2200);
        exp_wr(22'd21, 36'o400000002200);
        pulse_start(8'b0010_0010);
        wait_done(1);
        wait_done(5);

        // Simultaneous chReq[3] and chReq[6]: channel 3 granted first
        mem[22'd12]   = {14'b0, 22'o2400};
        mem[22'o2400] = {1'b1, 1'b1, 1'b0, 11'd1, 22'o5000};
        mem[22'd24]   = {14'b0, 22'o2500};
        mem[22'o2500] = {1'b1, 1'b1, 1'b0, 11'd1, 22'o6000};
        exp_rd(22'd12);
        exp_rd(22'o2400);
        exp_rd(22'd24);
        exp_rd(22'o2500);
        exp_wr(22'd13, 36'o400000002400);
        exp_wr(22'd25, 36'o400000002500);
        pulse_start(8'b0100_1000);
        wait_mem(2);
        repeat (3) @(negedge clk);
        chk("prio_both_active", 64'(chActive), 64'(8'b0100_1000));
        exp_gr(3, 22'o5000, 1'b0);
        exp_gr(6, 22'o6000, 1'b0);
        chReq = 8'b0100_1000;
        wait_done(3);
        wait_done(6);
        chReq = '0;

        // Error on CCW read, then restart clears the sticky flag
        mem[22'd8]    = {14'b0, 22'o2300};
        mem[22'o2300] = {1'b1, 1'b1, 1'b0, 11'd1, 22'o7000};
        err_addr = 22'o2300;
        err_arm  = 1'b1;
        exp_rd(22'd8);
        exp_rd(22'o2300);
        exp_wr(22'd9, 36'o600000002300);
        pulse_start(8'b0000_0100);
        wait_done(2);
        chk("err_sticky", 64'(chError), 64'(8'b0000_0100));
        mem[22'o2300] = '0;
        exp_rd(22'd8);
        exp_rd(22'o2300);
        exp_wr(22'd9, 36'o400000002300);
        pulse_start(8'b0000_0100);
        chk("err_cleared", 64'(chError[2]), 64'(0));
        wait_done(2);
        chk("err_after_clean", 64'(chError), 64'(0));

        // Reset in the middle of a data transfer
        mem[22'd16]   = {14'b0, 22'o2600};
        mem[22'o2600] = {1'b1, 1'b1, 1'b0, 11'd5, 22'o10000};
        exp_rd(22'd16);
        exp_rd(22'o2600);
        pulse_start(8'b0001_0000);
        wait_mem(0);
        repeat (2) @(negedge clk);
        chk("mid_active", 64'(chActive[4]), 64'(1));
        exp_gr(4, 22'o10000, 1'b0);
        exp_gr(4, 22'o10001, 1'b0);
        chReq = 8'b0001_0000;
        repeat (2) @(negedge clk);
        chReq = '0;
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_chActive", 64'(chActive), 64'(0));
        chk("abort_memReq", 64'(memReq), 64'(0));
        chk("abort_chGrant", 64'(chGrant), 64'(0));
        chk("abort_chDataValid", 64'(chDataValid), 64'(0));
        chk("abort_chDone", 64'(chDone), 64'(0));
        chk("abort_memAddr", 64'(memAddr), 64'(0));
        @(negedge clk);
        rst   = 1'b0;
        chReq = 8'b0001_0000;
        repeat (20) @(negedge clk);
        chReq = '0;
        chk("abort_still_idle", 64'(chActive), 64'(0));

        chk("mem_q_empty", 64'(mem_q.size()), 64'(0));
        chk("gnt_q_empty", 64'(gnt_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mbox_channel_ctl.md
Name: mbox_channel_ctl

Overview:
- Combined MBOX channel control: command-list logic, CCW buffer and channel address generation for 8 DMA channels.
- Fetches each channel's initial command-list pointer (ICP), then fetches and decodes channel command words (CCWs).
- Issues one data-word address per channel service request and writes a logout status word when the channel halts.
- Sits between the channel data paths (chc/chd) and the MBOX memory port.

Parameters:
- NCH, 8, number of channels (channel index 0..NCH-1).
- AW, 22, physical address width.

Ports:
- mboxClk in 1: MBOX clock; all state changes on its rising edge.
- reset in 1: asynchronous, active-high reset.
- chStart in NCH: one-cycle pulse per channel; starts that channel's command list.
- chReq in NCH: level; channel wants one data word serviced.
- memAck in 1: memory cycle complete; memRData is valid in the same cycle.
- memErr in 1: qualifies memAck; the cycle failed (NXM/parity).
- memRData in 36: memory read data.
- memReq out 1: memory request, held until memAck.
- memWrite out 1: request is a write.
- memAddr out AW: memory address.
- memWData out 36: memory write data.
- chGrant out NCH: one-hot, one-cycle grant of a data word.
- chDataValid out 1: chDataAddr is valid; asserted together with chGrant.
- chDataAddr out AW: memory address of the granted data word.
- chReverse out 1: direction bit of the granted word's CCW.
- chActive out NCH: channel is running.
- chDone out NCH: one-cycle pulse when a channel halts.
- chError out NCH: sticky error flag; cleared on that channel's next chStart.

Behaviour:
- Reset: every output 0. All channels inactive. Pending-start bits, CLP, WC, address, CCW flags and error flags all cleared. FSM goes to IDLE.
- Per-channel registers:
  - CLP (AW bits): command-list pointer.
  - WC (11 bits): word count.
  - DA (AW bits): data address.
  - Flags: halt-after, reverse.
- chStart[i] sets pending[i] and clears chError[i]. It is ignored while chActive[i]=1.
- FSM states: IDLE, ICP_RD, CCW_RD, STORE, DONE. Only one channel is served at a time; the channel being served is latched as cur.
- IDLE arbitration, fixed priority, lowest channel index wins:
  - Any pending[i] set: cur=i, clear pending[i], go to ICP_RD.
  - Otherwise, any chReq[i] with chActive[i]=1 and WC[i]!=0: pulse chGrant[i] and chDataValid for 1 cycle, with chDataAddr=DA[i] and chReverse=rev[i].
    - Next cycle: DA[i] = DA[i]-1 if rev[i] is set, else DA[i]+1; WC[i] = WC[i]-1.
    - If the new WC is 0: halt-after set → cur=i, go to STORE; else CLP[i]+=1, cur=i, go to CCW_RD.
  - Start service takes priority over data service.
- ICP_RD: read memAddr = 4*cur. On memAck: CLP = memRData[14:35], set chActive[cur], go to CCW_RD.
- CCW_RD: read memAddr = CLP[cur]. On memAck, decode memRData:
  - bit0=1 (data transfer): WC = bits 3:13, DA = bits 14:35, halt-after = bit1, reverse = bit2, return to IDLE. If WC=0, apply the end-of-count action immediately without granting any word.
  - bits0:1=01 (jump): CLP = bits 14:35, stay in CCW_RD.
  - bits0:1=00 (halt): go to STORE.
- Memory errors: memAck with memErr in any read state sets chError[cur] and goes to STORE.
- STORE: write to memAddr = 4*cur+1.
  - memWData bit0 = 1.
  - memWData bit1 = chError[cur].
  - memWData bit2 = 0.
  - memWData bits 3:13 = WC[cur].
  - memWData bits 14:35 = CLP[cur].
  - On memAck go to DONE; memErr during this write is ignored.
- DONE: pulse chDone[cur] for 1 cycle, clear chActive[cur], go to IDLE.
- Memory handshake:
  - memReq, memWrite, memAddr and memWData are registered and held stable until memAck.
  - memReq deasserts in the cycle after memAck.
  - Back-to-back requests are allowed from the cycle after that.
- Address arithmetic wraps modulo 2^AW. WC is never decremented below 0.
- chReq for an inactive channel, or a channel with WC=0, is ignored.
- reset at any time, including mid-cycle, aborts immediately; no logout is written.

Test Plan:
- Start channel 2; mem[8]=CLP 0o100; mem[0o100] = data CCW, halt-after, WC=3, DA=0o2000. Hold chReq[2] → three grants at 0o2000, 0o2001, 0o2002 → logout at addr 9 = bit0=1, WC=0, CLP=0o100 → chDone[2] pulse, chActive[2]=0.
- Reverse CCW with WC=2, DA=0o500 → grants at 0o500 then 0o477.
- Chained CCWs: data CCW without halt-after (WC=1), then a jump to 0o300, then a halt CCW at 0o300 → CCW fetch addresses CLP, CLP+1, 0o300 → logout CLP=0o300.
- Start channels 5 and 1 in the same cycle → channel 1 ICP read (addr 4) occurs before channel 5's (addr 20). Simultaneous chReq[3] and chReq[6] → chGrant=8'b00001000 first.
- memErr on the CCW read → chError set, logout bit1=1, chDone pulse. The next chStart clears chError.
- Assert reset mid-transfer → all outputs 0 and channel inactive immediately; no memory write follows.
